// File: rtl/contador_ascendente.sv
// Up-counter with debounced active-low increment button, clamped load and two
// active-low 7-segment digits. Define SATURATE_EN to hold at LIMIT instead of wrapping.
module contador_ascendente #(
  parameter int WIDTH = 6,
  parameter int LIMIT = 59
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] num,
  input  logic             load_n,
  input  logic             inc_n,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic [6:0]       seg,
  output logic [6:0]       seg_tens
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic       ff1;
  logic       ff2;
  logic       prev;
  logic [1:0] settle;
  logic       armed;
  logic       valid;
  logic       inc_evt;
  logic [31:0] value;

  // settle[1] marks ff2 as holding a real sample; armed needs one real released
  // sample, so a press held through reset release never counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff1    <= 1'b1;
      ff2    <= 1'b1;
      prev   <= 1'b1;
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      ff1    <= inc_n;
      ff2    <= ff1;
      prev   <= ff2;
      settle <= {settle[0], 1'b1};
      armed  <= armed | (settle[1] & ff2);
    end
  end

  assign inc_evt = armed & ~ff2 & prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out   <= '0;
      tc    <= 1'b0;
      valid <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (!load_n) begin
        out   <= (num > LIM) ? LIM : num;
        valid <= 1'b1;
      end else if (inc_evt) begin
        valid <= 1'b1;
`ifdef SATURATE_EN
        if (out != LIM) begin
          out <= out + WIDTH'(1);
          tc  <= ((out + WIDTH'(1)) == LIM);
        end
`else
        if (out == LIM) begin
          out <= '0;
          tc  <= 1'b1;
        end else begin
          out <= out + WIDTH'(1);
        end
`endif
      end
    end
  end

  function automatic logic [6:0] to_seg(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = 7'b0000001;
      4'd1:    code = 7'b1001111;
      4'd2:    code = 7'b0010010;
      4'd3:    code = 7'b0000110;
      4'd4:    code = 7'b1001100;
      4'd5:    code = 7'b0100100;
      4'd6:    code = 7'b0100000;
      4'd7:    code = 7'b0001111;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0000100;
      default: code = 7'b1111111;
    endcase
    return code;
  endfunction

  always_comb begin
    seg      = '1;
    seg_tens = '1;
    value    = 32'(out);
    if (valid) begin
      seg = to_seg(4'(value % 32'd10));
      if (value >= 32'd10) seg_tens = to_seg(4'(value / 32'd10));
    end
  end

endmodule

// File: tb/tb_contador_ascendente.sv
// Directed plus randomized bench for contador_ascendente; the reference model
// works on the raw history of sampled button levels rather than on flop state.
module tb_contador_ascendente;

  localparam int W   = 6;
  localparam int LIM = 59;

  logic         clk;
  logic         reset;
  logic [W-1:0] num;
  logic         load_n;
  logic         inc_n;
  logic [W-1:0] out;
  logic         tc;
  logic [6:0]   seg;
  logic [6:0]   seg_tens;

  contador_ascendente #(.WIDTH(W), .LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .num(num), .load_n(load_n), .inc_n(inc_n),
    .out(out), .tc(tc), .seg(seg), .seg_tens(seg_tens)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] CODES [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  int  vectors = 0;
  int  miscompares = 0;
  bit  samp[$];
  int  m_cnt = 0;
  bit  m_tc = 0;
  bit  m_valid = 0;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    samp.delete();
    m_cnt = 0;
    m_tc = 0;
    m_valid = 0;
  endtask

  // Count on a high-to-low step between two consecutive post-reset samples,
  // landing two edges after the first low sample.
  task automatic model_edge(input logic ld, input logic [W-1:0] n, input logic inc);
    int t;
    bit ev;
    samp.push_back(inc);
    t  = samp.size();
    ev = (t >= 4) && samp[t-4] && !samp[t-3];
    m_tc = 0;
    if (!ld) begin
      m_cnt = (int'(n) > LIM) ? LIM : int'(n);
      m_valid = 1;
    end else if (ev) begin
      m_valid = 1;
`ifdef SATURATE_EN
      if (m_cnt != LIM) begin
        m_cnt++;
        m_tc = (m_cnt == LIM);
      end
`else
      if (m_cnt == LIM) begin
        m_cnt = 0;
        m_tc = 1;
      end else begin
        m_cnt++;
      end
`endif
    end
  endtask

  task automatic check_all();
    logic [6:0] e_seg;
    logic [6:0] e_tens;
    e_seg  = m_valid ? CODES[m_cnt % 10] : 7'b1111111;
    e_tens = (m_valid && m_cnt >= 10) ? CODES[m_cnt / 10] : 7'b1111111;
    chk("out", {1'b0, out}, 7'(m_cnt));
    chk("tc", {6'b0, tc}, {6'b0, m_tc});
    chk("seg", seg, e_seg);
    chk("seg_tens", seg_tens, e_tens);
  endtask

  task automatic cyc(input logic ld, input logic [W-1:0] n, input logic inc);
    load_n = ld;
    num    = n;
    inc_n  = inc;
    @(posedge clk);
    model_edge(ld, n, inc);
    #1;
    check_all();
  endtask

  initial begin
    int run_left;
    logic cur;
    reset  = 1'b0;
    num    = 6'd8;
    load_n = 1'b1;
    inc_n  = 1'b1;
    model_reset();
    #12;
    chk("rst_out", {1'b0, out}, 7'd0);
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_tens", seg_tens, 7'b1111111);
    chk("rst_tc", {6'b0, tc}, 7'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) cyc(1'b1, 6'd8, 1'b1);

    cyc(1'b0, 6'd8, 1'b1);
    chk("t2_out", {1'b0, out}, 7'd8);
    chk("t2_seg", seg, 7'b0000000);
    chk("t2_tens", seg_tens, 7'b1111111);

    repeat (2) cyc(1'b1, 6'd0, 1'b0);
    chk("t3_before", {1'b0, out}, 7'd8);
    cyc(1'b1, 6'd0, 1'b0);
    chk("t3_third", {1'b0, out}, 7'd9);
    chk("t3_seg9", seg, 7'b0000100);
    repeat (2) cyc(1'b1, 6'd0, 1'b0);
    repeat (3) cyc(1'b1, 6'd0, 1'b1);
    repeat (4) cyc(1'b1, 6'd0, 1'b0);
    chk("t3_ten", {1'b0, out}, 7'd10);
    chk("t3_tens", seg_tens, 7'b1001111);
    repeat (3) cyc(1'b1, 6'd0, 1'b1);

    cyc(1'b0, 6'd63, 1'b1);
    chk("t4_clamp", {1'b0, out}, 7'd59);
    repeat (4) cyc(1'b1, 6'd0, 1'b0);
    repeat (3) cyc(1'b1, 6'd0, 1'b1);

    repeat (2) cyc(1'b1, 6'd0, 1'b0);
    cyc(1'b0, 6'd3, 1'b0);
    repeat (3) cyc(1'b1, 6'd0, 1'b0);
    chk("t5_drop", {1'b0, out}, 7'd3);
    repeat (3) cyc(1'b1, 6'd0, 1'b1);

    repeat (2) cyc(1'b1, 6'd0, 1'b0);
    #1 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;
    repeat (6) cyc(1'b1, 6'd0, 1'b0);
    chk("t6_held", {1'b0, out}, 7'd0);
    repeat (3) cyc(1'b1, 6'd0, 1'b1);
    repeat (3) cyc(1'b1, 6'd0, 1'b0);
    chk("t6_count", {1'b0, out}, 7'd1);

    run_left = 0;
    cur = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (run_left == 0) begin
        cur = ~cur;
        run_left = $urandom_range(1, 6);
      end
      run_left--;
      if ($urandom_range(0, 11) == 0)
        cyc(1'b0, W'($urandom_range(0, 63)), cur);
      else
        cyc(1'b1, W'($urandom_range(0, 63)), cur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
